// File: rtl/ir_fetch_sequencer.sv
// ir_fetch_sequencer
//   Fetches one 16-bit instruction into IR, one byte at a time. The block owns
//   the program counter and reads memory over a req/ack byte handshake. IR is
//   cleared first, then the low byte is loaded, then the high byte.
//   A byte that is not acknowledged within TIMEOUT request cycles parks the
//   sequencer in a fault state until FaultClr.
//
// Ports
//   Clock, Reset          rising-edge clock, asynchronous active-high reset
//   Start                 request one instruction fetch (IDLE only)
//   BranchEn, BranchAddr  load PC from BranchAddr (IDLE only)
//   FaultClr              leave the fault state
//   MemReq, MemAddr       byte read request and address (= PC)
//   MemAck, MemData       read data valid and read byte
//   IR_E, IR_FunSel       IR enable and function (00 clear, 01 load)
//   IR_LH, IR_Input       IR half select and byte to load
//   PC                    current program counter
//   Busy, Done, Fault     status: not idle, 1-cycle fetch complete, faulted

module ir_fetch_sequencer #(
   parameter int unsigned       ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       TIMEOUT  = 15
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic              BranchEn,
   input  logic [ADDR_W-1:0] BranchAddr,
   input  logic              FaultClr,
   output logic              MemReq,
   output logic [ADDR_W-1:0] MemAddr,
   input  logic              MemAck,
   input  logic [7:0]        MemData,
   output logic              IR_E,
   output logic [1:0]        IR_FunSel,
   output logic              IR_LH,
   output logic [7:0]        IR_Input,
   output logic [ADDR_W-1:0] PC,
   output logic              Busy,
   output logic              Done,
   output logic              Fault
);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StReqLo,
      StReqHi,
      StDone,
      StFault
   } state_e;

   localparam logic [7:0]        TimeoutLim = 8'(TIMEOUT);
   localparam logic [ADDR_W-1:0] PcOne      = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [7:0]        tmo_q, tmo_d;
   logic [7:0]        tmo_inc;

   assign tmo_inc = tmo_q + 8'd1;
   assign PC      = pc_q;
   assign Busy    = (state_q != StIdle);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
         tmo_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      tmo_d     = tmo_q;
      MemReq    = 1'b0;
      MemAddr   = '0;
      IR_E      = 1'b0;
      IR_FunSel = 2'b00;
      IR_LH     = 1'b0;
      IR_Input  = 8'h00;
      Done      = 1'b0;
      Fault     = 1'b0;

      unique case (state_q)
         StIdle: begin
            // A branch and a start in the same cycle fetch from the branch target.
            if (BranchEn) pc_d = BranchAddr;
            if (Start) state_d = StClear;
         end
         StClear: begin
            IR_E      = 1'b1;
            IR_FunSel = 2'b00;
            tmo_d     = 8'd0;
            state_d   = StReqLo;
         end
         StReqLo, StReqHi: begin
            MemReq  = 1'b1;
            MemAddr = pc_q;
            if (MemAck) begin
               // Ack is honoured in the same cycle: the byte goes straight to IR.
               IR_E      = 1'b1;
               IR_FunSel = 2'b01;
               IR_LH     = (state_q == StReqHi);
               IR_Input  = MemData;
               pc_d      = pc_q + PcOne;
               tmo_d     = 8'd0;
               state_d   = (state_q == StReqHi) ? StDone : StReqHi;
            end else begin
               // PC stays on the unacknowledged byte if this times out.
               tmo_d = tmo_inc;
               if (tmo_inc >= TimeoutLim) state_d = StFault;
            end
         end
         StDone: begin
            Done    = 1'b1;
            state_d = StIdle;
         end
         StFault: begin
            Fault = 1'b1;
            if (FaultClr) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
`timescale 1ns/1ps

module tb_ir_fetch_sequencer;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Start;
   logic        BranchEn;
   logic [15:0] BranchAddr;
   logic        FaultClr;
   logic        MemReq;
   logic [15:0] MemAddr;
   logic        MemAck;
   logic [7:0]  MemData;
   logic        IR_E;
   logic [1:0]  IR_FunSel;
   logic        IR_LH;
   logic [7:0]  IR_Input;
   logic [15:0] PC;
   logic        Busy;
   logic        Done;
   logic        Fault;

   int vectors = 0;
   int miscompares = 0;

   // IR register as seen by the bench, updated from the IR control outputs.
   logic [15:0] ir_model = 16'hDEAD;

   ir_fetch_sequencer #(
      .ADDR_W  (16),
      .RESET_PC(16'h0000),
      .TIMEOUT (15)
   ) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Start     (Start),
      .BranchEn  (BranchEn),
      .BranchAddr(BranchAddr),
      .FaultClr  (FaultClr),
      .MemReq    (MemReq),
      .MemAddr   (MemAddr),
      .MemAck    (MemAck),
      .MemData   (MemData),
      .IR_E      (IR_E),
      .IR_FunSel (IR_FunSel),
      .IR_LH     (IR_LH),
      .IR_Input  (IR_Input),
      .PC        (PC),
      .Busy      (Busy),
      .Done      (Done),
      .Fault     (Fault)
   );

   always #5 Clock = ~Clock;

   task automatic cyc();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply_ir();
      if (IR_E) begin
         if (IR_FunSel == 2'b00) ir_model = 16'h0000;
         else if (IR_FunSel == 2'b01) begin
            if (IR_LH) ir_model[15:8] = IR_Input;
            else       ir_model[7:0]  = IR_Input;
         end else ir_model = 16'hxxxx;
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1; Start = 1'b0; BranchEn = 1'b0; BranchAddr = 16'h0000;
      FaultClr = 1'b0; MemAck = 1'b0; MemData = 8'h00;
      cyc();
      Reset = 1'b0;
      #1;
   endtask

   // Runs one fetch from IDLE; caller may preset BranchEn/BranchAddr.
   // Returns at the DONE cycle (or when the cycle budget expires).
   task automatic do_fetch(input int dly_lo, input int dly_hi,
                           input logic [7:0] b_lo, input logic [7:0] b_hi,
                           output int done_cyc, output logic [15:0] addr_lo,
                           output logic [15:0] addr_hi, output int ire_cnt,
                           output int req_cyc);
      int c = 0;
      int phase = 0;
      int wcnt = 0;
      done_cyc = -1; addr_lo = 16'hxxxx; addr_hi = 16'hxxxx; ire_cnt = 0; req_cyc = 0;
      Start = 1'b1;
      while (c < 60 && done_cyc < 0) begin
         cyc();
         c++;
         Start = 1'b0; BranchEn = 1'b0; MemAck = 1'b0; MemData = 8'h00;
         #1;
         if (MemReq) begin
            req_cyc++;
            if (wcnt == ((phase == 0) ? dly_lo : dly_hi)) begin
               MemAck  = 1'b1;
               MemData = (phase == 0) ? b_lo : b_hi;
               if (phase == 0) addr_lo = MemAddr; else addr_hi = MemAddr;
               phase++;
               wcnt = 0;
            end else wcnt++;
         end
         #1;
         if (IR_E) ire_cnt++;
         apply_ir();
         if (Done) done_cyc = c;
      end
      if (done_cyc < 0) $display("FAIL fetch_timeout: got no Done expected Done");
   endtask

   task automatic test_reset();
      do_reset();
      chk("rst_busy", 16'(Busy), 16'd0);
      chk("rst_done", 16'(Done), 16'd0);
      chk("rst_fault", 16'(Fault), 16'd0);
      chk("rst_memreq", 16'(MemReq), 16'd0);
      chk("rst_ire", 16'(IR_E), 16'd0);
      chk("rst_pc", PC, 16'h0000);
   endtask

   task automatic test_basic_fetch();
      int d, ic, rc;
      logic [15:0] al, ah;
      do_reset();
      do_fetch(0, 0, 8'h34, 8'h12, d, al, ah, ic, rc);
      chk("basic_done_cycle", 16'(d), 16'd4);
      chk("basic_ir", ir_model, 16'h1234);
      chk("basic_pc", PC, 16'h0002);
      chk("basic_addr_lo", al, 16'h0000);
      chk("basic_addr_hi", ah, 16'h0001);
      chk("basic_ire_count", 16'(ic), 16'd3);
      cyc();
      chk("basic_idle_busy", 16'(Busy), 16'd0);
      chk("basic_done_pulse", 16'(Done), 16'd0);
   endtask

   task automatic test_delayed_ack();
      int d, ic, rc;
      logic [15:0] al, ah;
      do_reset();
      do_fetch(3, 3, 8'hCD, 8'hAB, d, al, ah, ic, rc);
      chk("delay_done_cycle", 16'(d), 16'd10);
      chk("delay_ir", ir_model, 16'hABCD);
      chk("delay_pc", PC, 16'h0002);
      chk("delay_ire_count", 16'(ic), 16'd3);
      chk("delay_req_cycles", 16'(rc), 16'd8);
      cyc();
   endtask

   task automatic test_branch_wrap();
      int d, ic, rc;
      logic [15:0] al, ah;
      BranchEn = 1'b1;
      BranchAddr = 16'hFFFF;
      do_fetch(0, 0, 8'h01, 8'h80, d, al, ah, ic, rc);
      chk("wrap_addr_lo", al, 16'hFFFF);
      chk("wrap_addr_hi", ah, 16'h0000);
      chk("wrap_ir", ir_model, 16'h8001);
      cyc();
      chk("wrap_pc", PC, 16'h0001);
   endtask

   task automatic test_timeout();
      int n = 0;
      do_reset();
      Start = 1'b1;
      cyc();                               // CLEAR
      Start = 1'b0;
      cyc();                               // REQ_LO
      MemAck = 1'b1; MemData = 8'h11;
      cyc();                               // REQ_HI
      MemAck = 1'b0;
      #1;
      while (MemReq && !Fault && n < 40) begin
         n++;
         cyc();
      end
      chk("tmo_req_cycles", 16'(n), 16'd15);
      chk("tmo_fault", 16'(Fault), 16'd1);
      chk("tmo_pc", PC, 16'h0001);
      Start = 1'b1; MemAck = 1'b1;
      cyc();
      chk("tmo_start_ignored", 16'(Fault), 16'd1);
      chk("tmo_memreq", 16'(MemReq), 16'd0);
      chk("tmo_ire", 16'(IR_E), 16'd0);
      Start = 1'b0; MemAck = 1'b0; FaultClr = 1'b1;
      cyc();
      FaultClr = 1'b0;
      chk("tmo_clr_fault", 16'(Fault), 16'd0);
      chk("tmo_clr_busy", 16'(Busy), 16'd0);
      chk("tmo_clr_pc", PC, 16'h0001);
   endtask

   task automatic test_reset_midfetch();
      int d, ic, rc;
      logic [15:0] al, ah;
      do_reset();
      Start = 1'b1;
      cyc();
      Start = 1'b0;
      apply_ir();
      cyc();
      MemAck = 1'b1; MemData = 8'h55;
      #1;
      apply_ir();
      cyc();                               // REQ_HI
      #1;
      Reset = 1'b1;
      #1;
      chk("mid_memreq", 16'(MemReq), 16'd0);
      chk("mid_ire", 16'(IR_E), 16'd0);
      chk("mid_busy", 16'(Busy), 16'd0);
      chk("mid_pc", PC, 16'h0000);
      MemAck = 1'b0;
      #1;
      Reset = 1'b0;
      do_fetch(0, 0, 8'h78, 8'h56, d, al, ah, ic, rc);
      chk("mid_refetch_ir", ir_model, 16'h5678);
      chk("mid_refetch_done", 16'(d), 16'd4);
      cyc();
   endtask

   task automatic test_spurious();
      int ire = 0;
      int dones = 0;
      do_reset();
      MemAck = 1'b1; MemData = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         cyc();
         if (IR_E) ire++;
         if (Done) dones++;
      end
      chk("spur_idle_ire", 16'(ire), 16'd0);
      chk("spur_idle_pc", PC, 16'h0000);
      MemAck = 1'b0;
      Start = 1'b1;
      cyc();                               // CLEAR
      BranchEn = 1'b1; BranchAddr = 16'h4000;
      chk("spur_clear_funsel", 16'(IR_FunSel), 16'd0);
      cyc();                               // REQ_LO, no ack
      cyc();                               // REQ_LO, no ack
      chk("spur_req_addr", MemAddr, 16'h0000);
      MemAck = 1'b1;
      cyc();                               // REQ_HI
      cyc();                               // DONE
      Start = 1'b0; BranchEn = 1'b0; MemAck = 1'b1;
      #1;
      chk("spur_done", 16'(Done), 16'd1);
      chk("spur_pc", PC, 16'h0002);
      dones = 0; ire = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         if (IR_E) ire++;
         if (Done) dones++;
      end
      MemAck = 1'b0;
      chk("spur_extra_done", 16'(dones), 16'd0);
      chk("spur_post_ire", 16'(ire), 16'd0);
      chk("spur_post_pc", PC, 16'h0002);
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_delayed_ack();
      test_branch_wrap();
      test_timeout();
      test_reset_midfetch();
      test_spurious();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
